// File: rtl/quad_pkg.sv
// Quadrature decoder shared definitions.
// Command codes are {load,count}; phase codes are the {A,B} pin pair.
package quad_pkg;

   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_UP   = 2'b01;
   localparam logic [1:0] CMD_LOAD = 2'b10;
   localparam logic [1:0] CMD_DOWN = 2'b11;

   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_10 = 2'b10,
      PH_11 = 2'b11,
      PH_01 = 2'b01
   } phase_t;

   function automatic logic [1:0] ph_fwd(input logic [1:0] p);
      logic [1:0] r;
      r = PH_00;
      unique case (p)
         PH_00: r = PH_10;
         PH_10: r = PH_11;
         PH_11: r = PH_01;
         PH_01: r = PH_00;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] ph_rev(input logic [1:0] p);
      logic [1:0] r;
      r = PH_00;
      unique case (p)
         PH_00: r = PH_01;
         PH_01: r = PH_11;
         PH_11: r = PH_10;
         PH_10: r = PH_00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Pin front end: 2-flop synchroniser plus run-length glitch filter.
// nxt is the value the synchroniser presents next; warm-up copies it.
module quad_input_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic clr,
   input  logic pin,
   input  logic warm,
   output logic nxt,
   output logic filt
);

   logic s1;
   logic s2;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= pin;
         s2 <= s1;
      end
   end

   assign nxt = s1;

   generate
      if (FILTER_LEN == 0) begin : g_bypass
         wire unused_warm = warm;
         assign filt = s2;
      end else begin : g_filt
         localparam int CW = $clog2(FILTER_LEN + 1);
         logic [CW-1:0] run;
         logic          held;

         // a bounce back to the held value restarts the run
         always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
               run  <= '0;
               held <= 1'b0;
            end else if (warm) begin
               run  <= '0;
               held <= s1;
            end else if (s2 == held) begin
               run <= '0;
            end else if (run == CW'(FILTER_LEN - 1)) begin
               run  <= '0;
               held <= s2;
            end else begin
               run <= run + 1'b1;
            end
         end

         assign filt = held;
      end
   endgenerate

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder driving {load,count} of a position counter.
// Flags double transitions and keeps a saturating error count.
module quad_step_decoder
   import quad_pkg::*;
#(
   parameter int FILTER_LEN   = 3,
   parameter int ERR_CNT_BITS = 8
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    en,
   input  logic                    a_in,
   input  logic                    b_in,
   input  logic                    idx_in,
   output logic                    load,
   output logic                    count,
   output logic                    step,
   output logic                    dir,
   output logic                    err,
   output logic [ERR_CNT_BITS-1:0] err_cnt
);

   logic [1:0] warm_cnt;
   logic       warm;
   logic       fa, fb, fi;
   logic       na, nb, ni;
   logic [1:0] ab;
   logic [1:0] phase;
   logic       idx_q;

   logic       fwd, rev, dbl, rise, act;
   logic       up, dn;
   logic [1:0] cmd_n;
   logic       step_n, dir_n, err_n;

   quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_a (
      .clk(clk), .clr(clr), .pin(a_in),
      .warm(warm), .nxt(na), .filt(fa)
   );

   quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_b (
      .clk(clk), .clr(clr), .pin(b_in),
      .warm(warm), .nxt(nb), .filt(fb)
   );

   quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_i (
      .clk(clk), .clr(clr), .pin(idx_in),
      .warm(warm), .nxt(ni), .filt(fi)
   );

   assign warm = (warm_cnt != 2'd0);
   assign ab   = {fa, fb};

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         warm_cnt <= 2'd2;
      else if (warm)
         warm_cnt <= warm_cnt - 2'd1;
   end

   assign fwd  = (ab == ph_fwd(phase));
   assign rev  = (ab == ph_rev(phase));
   assign dbl  = (ab == ~phase);
   assign rise = fi & ~idx_q;
   assign act  = en & ~warm;
   assign up   = fwd & ~rise;
   assign dn   = rev & ~rise;

   always_comb begin
      cmd_n  = CMD_HOLD;
      step_n = 1'b0;
      dir_n  = dir;
      err_n  = 1'b0;
      if (act) begin
         err_n = dbl;
         unique case (1'b1)
            rise: cmd_n = CMD_LOAD;
            up: begin
               cmd_n  = CMD_UP;
               step_n = 1'b1;
               dir_n  = 1'b1;
            end
            dn: begin
               cmd_n  = CMD_DOWN;
               step_n = 1'b1;
               dir_n  = 1'b0;
            end
            default: cmd_n = CMD_HOLD;
         endcase
      end
   end

   // warm-up loads what the synchroniser is about to show
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         phase <= PH_00;
         idx_q <= 1'b0;
      end else if (warm) begin
         phase <= {na, nb};
         idx_q <= ni;
      end else begin
         phase <= ab;
         idx_q <= fi;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         load    <= 1'b0;
         count   <= 1'b0;
         step    <= 1'b0;
         dir     <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         {load, count} <= cmd_n;
         step          <= step_n;
         dir           <= dir_n;
         err           <= err_n;
         if (err_n && !(&err_cnt))
            err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench: two decoders (filter 0 / filter 3) share random pins.
// A position-arithmetic model predicts each command and its cycle.
module tb_quad_step_decoder;

   logic clk = 1'b0;
   logic clr;
   logic en;
   logic a_in, b_in, idx_in;

   logic       ld0, ct0, st0, dr0, er0;
   logic [7:0] ec0;
   logic       ld3, ct3, st3, dr3, er3;
   logic [1:0] ec3;

   always #5 clk = ~clk;

   quad_step_decoder #(.FILTER_LEN(0), .ERR_CNT_BITS(8)) u_d0 (
      .clk(clk), .clr(clr), .en(en),
      .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
      .load(ld0), .count(ct0), .step(st0),
      .dir(dr0), .err(er0), .err_cnt(ec0)
   );

   quad_step_decoder #(.FILTER_LEN(3), .ERR_CNT_BITS(2)) u_d3 (
      .clk(clk), .clr(clr), .en(en),
      .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
      .load(ld3), .count(ct3), .step(st3),
      .dir(dr3), .err(er3), .err_cnt(ec3)
   );

   typedef struct {
      int         cyc;
      logic [1:0] cmd;
      logic       step;
      logic       dir;
      logic       err;
      int         ec;
   } exp_t;

   exp_t q0[$];
   exp_t q3[$];

   int         flen [2];
   int         emax [2];
   logic [1:0] m_ab [2];
   logic       m_i  [2];
   logic       m_dir[2];
   int         m_ec [2];
   logic [1:0] gray [4];

   int         cyc = 0;
   int         passed = 0;
   int         total = 0;
   logic [2:0] pins;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   function automatic int pos(input logic [1:0] v);
      for (int i = 0; i < 4; i++)
         if (gray[i] == v) return i;
      return 0;
   endfunction

   // quarter-turn distance between old and new pin pair decides the command
   task automatic model(input int d, input logic [2:0] p,
                        input logic e, input int k);
      exp_t x;
      int   dl;
      logic rise;
      dl   = (pos(p[2:1]) - pos(m_ab[d]) + 4) % 4;
      rise = p[0] & ~m_i[d];
      m_ab[d] = p[2:1];
      m_i[d]  = p[0];
      if (!e) return;
      x.cmd  = 2'b00;
      x.step = 1'b0;
      x.err  = 1'b0;
      if (dl == 2) begin
         x.err = 1'b1;
         if (m_ec[d] < emax[d]) m_ec[d]++;
      end
      if (rise) x.cmd = 2'b10;
      else if (dl == 1) begin
         x.cmd = 2'b01; x.step = 1'b1; m_dir[d] = 1'b1;
      end else if (dl == 3) begin
         x.cmd = 2'b11; x.step = 1'b1; m_dir[d] = 1'b0;
      end
      x.dir = m_dir[d];
      x.ec  = m_ec[d];
      x.cyc = k + 3 + flen[d];
      if (x.cmd != 2'b00 || x.err) begin
         if (d == 0) q0.push_back(x);
         else q3.push_back(x);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // a pin state held shorter than the filter length never reaches decode
   task automatic drive(input logic [2:0] p, input logic e, input int hold);
      pins = p;
      {a_in, b_in, idx_in} = p;
      en = e;
      for (int d = 0; d < 2; d++)
         if (hold >= flen[d]) model(d, p, e, cyc);
      wait_cyc(hold);
   endtask

   task automatic glitch(input int bitn, input int len);
      logic [2:0] o;
      logic [2:0] g;
      o = pins;
      g = pins ^ (3'b001 << bitn);
      drive(g, en, len);
      drive(o, en, 10);
   endtask

   task automatic mon(input int d, input logic [1:0] cmd, input logic st,
                      input logic dr, input logic er, input int ec);
      exp_t x;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q3.size() == 0)) begin
         total++;
         $display("FAIL d%0d unexpected output: cmd=%b step=%b err=%b cycle %0d",
                  d, cmd, st, er, cyc);
         return;
      end
      if (d == 0) x = q0.pop_front();
      else x = q3.pop_front();
      chk($sformatf("d%0d cycle", d), cyc, x.cyc);
      chk($sformatf("d%0d cmd", d), int'(cmd), int'(x.cmd));
      chk($sformatf("d%0d step", d), int'(st), int'(x.step));
      chk($sformatf("d%0d dir", d), int'(dr), int'(x.dir));
      chk($sformatf("d%0d err", d), int'(er), int'(x.err));
      chk($sformatf("d%0d err_cnt", d), ec, x.ec);
   endtask

   always @(negedge clk) begin
      if (!clr) begin
         if (ld0 | ct0 | st0 | er0)
            mon(0, {ld0, ct0}, st0, dr0, er0, int'(ec0));
         if (ld3 | ct3 | st3 | er3)
            mon(1, {ld3, ct3}, st3, dr3, er3, int'(ec3));
      end
   end

   task automatic chk_idle(input string tag);
      chk({tag, " d0 cmd"}, int'({ld0, ct0}), 0);
      chk({tag, " d0 step"}, int'(st0), 0);
      chk({tag, " d0 dir"}, int'(dr0), 0);
      chk({tag, " d0 err"}, int'(er0), 0);
      chk({tag, " d0 err_cnt"}, int'(ec0), 0);
      chk({tag, " d3 cmd"}, int'({ld3, ct3}), 0);
      chk({tag, " d3 step"}, int'(st3), 0);
      chk({tag, " d3 dir"}, int'(dr3), 0);
      chk({tag, " d3 err"}, int'(er3), 0);
      chk({tag, " d3 err_cnt"}, int'(ec3), 0);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ab[d]  = pins[2:1];
         m_i[d]   = pins[0];
         m_dir[d] = 1'b0;
         m_ec[d]  = 0;
      end
   endtask

   task automatic rand_ev();
      int         r;
      logic       e;
      logic [2:0] p;
      r = $urandom_range(0, 9);
      e = ($urandom_range(0, 4) != 0);
      p = pins;
      if (r <= 3) p[2:1] = gray[(pos(pins[2:1]) + 1) % 4];
      else if (r <= 6) p[2:1] = gray[(pos(pins[2:1]) + 3) % 4];
      else if (r == 7) p[2:1] = ~pins[2:1];
      if (r == 8 || (r <= 6 && $urandom_range(0, 3) == 0)) p[0] = ~p[0];
      if (r == 9) begin
         en = e;
         glitch($urandom_range(0, 2), $urandom_range(1, 7));
      end else begin
         drive(p, e, $urandom_range(8, 12));
      end
   endtask

   initial begin
      flen = '{0, 3};
      emax = '{255, 3};
      gray = '{2'b00, 2'b10, 2'b11, 2'b01};
      clr  = 1'b1;
      en   = 1'b1;
      pins = 3'b110;
      {a_in, b_in, idx_in} = pins;
      wait_cyc(3);
      clr = 1'b0;
      model_reset();
      wait_cyc(5);
      chk_idle("reset");

      // forward lap, reverse lap, then a double transition
      drive(3'b010, 1'b1, 8);
      drive(3'b000, 1'b1, 8);
      drive(3'b100, 1'b1, 8);
      drive(3'b110, 1'b1, 8);
      drive(3'b010, 1'b1, 8);
      drive(3'b000, 1'b1, 8);
      drive(3'b010, 1'b1, 8);
      drive(3'b110, 1'b1, 8);
      drive(3'b100, 1'b1, 8);
      drive(3'b000, 1'b1, 8);
      drive(3'b110, 1'b1, 8);

      // short pulse is bounce for the filtered decoder, long one is not
      glitch(2, 2);
      glitch(2, 6);

      // index rising with a forward step wins; next step decodes normally
      drive(3'b011, 1'b1, 8);
      drive(3'b001, 1'b1, 8);
      drive(3'b000, 1'b1, 8);

      for (int i = 0; i < 6; i++)
         drive(i % 2 == 0 ? 3'b110 : 3'b000, 1'b1, 8);
      wait_cyc(4);
      chk("d3 err_cnt saturated", int'(ec3), 3);
      chk("d0 err_cnt", int'(ec0), m_ec[0]);

      // disabled: phase tracks, nothing is emitted
      drive(3'b100, 1'b0, 8);
      drive(3'b110, 1'b0, 8);
      drive(3'b011, 1'b0, 8);
      drive(3'b100, 1'b0, 8);
      drive(3'b100, 1'b1, 10);
      drive(3'b110, 1'b1, 8);

      for (int i = 0; i < 120; i++) rand_ev();

      // reset while a command is on the outputs
      en = 1'b1;
      drive({gray[(pos(pins[2:1]) + 1) % 4], pins[0]}, 1'b1, 3);
      chk("pre-clr d0 count", int'(ct0), 1);
      clr = 1'b1;
      #1;
      chk_idle("clr");
      q0.delete();
      q3.delete();
      wait_cyc(3);
      clr = 1'b0;
      model_reset();
      wait_cyc(5);
      chk_idle("post-clr");

      for (int i = 0; i < 40; i++) rand_ev();

      wait_cyc(20);
      chk("d0 queue drained", q0.size(), 0);
      chk("d3 queue drained", q3.size(), 0);
      chk("d0 final err_cnt", int'(ec0), m_ec[0]);
      chk("d3 final err_cnt", int'(ec3), m_ec[1]);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
